// File: rtl/microwave_pkg.sv
// Shared types and constants for the microwave time-keeping path.
package microwave_pkg;

    typedef logic [3:0] bcd_t;

    localparam int KEY_W = 10;

    localparam bcd_t SEC_TENS_WRAP = 4'd5;
    localparam bcd_t SEC_ONES_WRAP = 4'd9;

    typedef enum logic {
        KEY_IDLE,
        KEY_HELD
    } key_state_t;

endpackage

// File: rtl/keypad_encoder.sv
// Registers the keypad, decodes one-hot digits and emits one press pulse per key
// stroke, regardless of how long the key is held.
module keypad_encoder
    import microwave_pkg::*;
#(
    parameter int WIDTH = KEY_W
) (
    input  logic             clk,
    input  logic             clearn,
    input  logic [WIDTH-1:0] keypad,
    output logic             press,
    output bcd_t             digit
);

    logic [WIDTH-1:0] key_q;
    logic             valid;
    key_state_t       state;
    key_state_t       state_next;

    // Reset parks the FSM in HELD so a key held through reset needs a release.
    always_ff @(posedge clk) begin
        if (!clearn) begin
            key_q <= '0;
            state <= KEY_HELD;
        end else begin
            key_q <= keypad;
            state <= state_next;
        end
    end

    assign valid = $onehot(key_q);

    always_comb begin
        digit = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (key_q[i]) begin
                digit = bcd_t'(i);
            end
        end
    end

    // Any nonzero code consumes the press; only a clean one-hot code reports it.
    always_comb begin
        state_next = state;
        press      = 1'b0;
        case (state)
            KEY_IDLE: begin
                if (key_q != '0) begin
                    state_next = KEY_HELD;
                    press      = valid;
                end
            end
            KEY_HELD: begin
                if (key_q == '0) begin
                    state_next = KEY_IDLE;
                end
            end
            default: state_next = KEY_IDLE;
        endcase
    end

endmodule

// File: rtl/countdown_timer.sv
// Three-digit BCD entry register (M:ST:SO) that counts down once per second
// while cooking, with zero/tick/done flags for the cook controller.
module countdown_timer
    import microwave_pkg::*;
#(
    parameter int CLK_DIV = 50
) (
    input  logic             clk,
    input  logic             clearn,
    input  logic [KEY_W-1:0] keypad,
    input  logic             load_en,
    input  logic             count_en,
    output bcd_t             sec_ones,
    output bcd_t             sec_tens,
    output bcd_t             mins,
    output logic             zero,
    output logic             tick,
    output logic             done
);

    localparam int               PRE_W    = $clog2(CLK_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);

    logic             press;
    bcd_t             key_digit;
    logic [PRE_W-1:0] prescaler;
    logic             wrap;
    logic             decrement;
    logic             last_second;
    bcd_t             ones_dec;
    bcd_t             tens_dec;
    bcd_t             mins_dec;

    keypad_encoder #(
        .WIDTH (KEY_W)
    ) u_keypad_encoder (
        .clk    (clk),
        .clearn (clearn),
        .keypad (keypad),
        .press  (press),
        .digit  (key_digit)
    );

    assign zero        = (mins == 4'd0) && (sec_tens == 4'd0) && (sec_ones == 4'd0);
    assign wrap        = (prescaler == PRE_LAST);
    assign decrement   = count_en && !zero && wrap;
    assign last_second = (mins == 4'd0) && (sec_tens == 4'd0) && (sec_ones == 4'd1);

    // Borrow chain: ones wrap to 9, tens wrap to 5 (tens digits above 5 still count down).
    always_comb begin
        ones_dec = sec_ones - 4'd1;
        tens_dec = sec_tens;
        mins_dec = mins;
        if (sec_ones == 4'd0) begin
            ones_dec = SEC_ONES_WRAP;
            if (sec_tens != 4'd0) begin
                tens_dec = sec_tens - 4'd1;
            end else begin
                tens_dec = SEC_TENS_WRAP;
                mins_dec = mins - 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!clearn) begin
            prescaler <= '0;
            mins      <= '0;
            sec_tens  <= '0;
            sec_ones  <= '0;
            tick      <= 1'b0;
            done      <= 1'b0;
        end else begin
            tick <= decrement;
            done <= decrement && last_second;

            // Pausing keeps the partial second; reaching zero discards it.
            if (zero) begin
                prescaler <= '0;
            end else if (count_en) begin
                prescaler <= wrap ? '0 : prescaler + 1'b1;
            end

            if (decrement) begin
                mins     <= mins_dec;
                sec_tens <= tens_dec;
                sec_ones <= ones_dec;
            end else if (press && load_en && !count_en) begin
                mins     <= sec_tens;
                sec_tens <= sec_ones;
                sec_ones <= key_digit;
            end
        end
    end

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: key entry table plus hand-written
// countdown, pause, hold and reset sequences.
module tb_countdown_timer;

    localparam int CLK_DIV = 4;

    logic       clk;
    logic       clearn;
    logic [9:0] keypad;
    logic       load_en;
    logic       count_en;
    logic [3:0] sec_ones;
    logic [3:0] sec_tens;
    logic [3:0] mins;
    logic       zero;
    logic       tick;
    logic       done;

    int pass_count;
    int check_count;

    typedef struct {
        logic [9:0] kp;
        logic       le;
        logic       ce;
        logic [3:0] m;
        logic [3:0] t;
        logic [3:0] o;
        logic       z;
    } vec_t;

    vec_t vecs[13];

    countdown_timer #(
        .CLK_DIV (CLK_DIV)
    ) dut (
        .clk      (clk),
        .clearn   (clearn),
        .keypad   (keypad),
        .load_en  (load_en),
        .count_en (count_en),
        .sec_ones (sec_ones),
        .sec_tens (sec_tens),
        .mins     (mins),
        .zero     (zero),
        .tick     (tick),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [9:0] kp, input logic le, input logic ce);
        keypad   = kp;
        load_en  = le;
        count_en = ce;
        step();
    endtask

    task automatic pressKey(input int d, input int hold, input logic le, input logic ce);
        logic [9:0] kp;
        kp = 10'b1 << d;
        for (int i = 0; i < hold; i++) applyStimulus(kp, le, ce);
        applyStimulus(10'd0, le, ce);
        applyStimulus(10'd0, le, ce);
    endtask

    task automatic doReset(input logic [9:0] kp, input logic ce);
        clearn   = 1'b0;
        keypad   = kp;
        count_en = ce;
        step();
        clearn = 1'b1;
    endtask

    task automatic checkOutput(input string name, input logic [3:0] em, input logic [3:0] et,
                               input logic [3:0] eo, input logic ez, input logic etick,
                               input logic edone);
        check_count++;
        if ({mins, sec_tens, sec_ones, zero, tick, done} === {em, et, eo, ez, etick, edone}) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got %0d:%0d%0d zero=%b tick=%b done=%b, expected %0d:%0d%0d zero=%b tick=%b done=%b",
                     name, mins, sec_tens, sec_ones, zero, tick, done, em, et, eo, ez, etick, edone);
        end
    endtask

    task automatic checkCount(input string name, input int got, input int exp);
        check_count++;
        if (got == exp) pass_count++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
    endtask

    task automatic runCount(input int cycles, output int ticks, output int dones);
        ticks = 0;
        dones = 0;
        for (int i = 0; i < cycles; i++) begin
            step();
            if (tick === 1'b1) ticks++;
            if (done === 1'b1) dones++;
        end
    endtask

    initial begin
        int ticks;
        int dones;
        pass_count  = 0;
        check_count = 0;
        clearn   = 1'b0;
        keypad   = '0;
        load_en  = 1'b0;
        count_en = 1'b0;
        step();
        doReset(10'd0, 1'b0);
        checkOutput("reset_state", 0, 0, 0, 1, 0, 0);

        // Entry 2,5,4 then an invalid code and a press with load disabled
        vecs[0]  = '{10'd0,         1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 1'b1};
        vecs[1]  = '{10'b0000000100, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 1'b1};
        vecs[2]  = '{10'd0,         1'b1, 1'b0, 4'd0, 4'd0, 4'd2, 1'b0};
        vecs[3]  = '{10'b0000100000, 1'b1, 1'b0, 4'd0, 4'd0, 4'd2, 1'b0};
        vecs[4]  = '{10'd0,         1'b1, 1'b0, 4'd0, 4'd2, 4'd5, 1'b0};
        vecs[5]  = '{10'b0000010000, 1'b1, 1'b0, 4'd0, 4'd2, 4'd5, 1'b0};
        vecs[6]  = '{10'd0,         1'b1, 1'b0, 4'd2, 4'd5, 4'd4, 1'b0};
        vecs[7]  = '{10'b0000000101, 1'b1, 1'b0, 4'd2, 4'd5, 4'd4, 1'b0};
        vecs[8]  = '{10'd0,         1'b1, 1'b0, 4'd2, 4'd5, 4'd4, 1'b0};
        vecs[9]  = '{10'd0,         1'b1, 1'b0, 4'd2, 4'd5, 4'd4, 1'b0};
        vecs[10] = '{10'b1000000000, 1'b0, 1'b0, 4'd2, 4'd5, 4'd4, 1'b0};
        vecs[11] = '{10'd0,         1'b0, 1'b0, 4'd2, 4'd5, 4'd4, 1'b0};
        vecs[12] = '{10'd0,         1'b0, 1'b0, 4'd2, 4'd5, 4'd4, 1'b0};
        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i].kp, vecs[i].le, vecs[i].ce);
            checkOutput($sformatf("entry_vec%0d", i), vecs[i].m, vecs[i].t, vecs[i].o,
                        vecs[i].z, 1'b0, 1'b0);
        end

        // One minute countdown
        pressKey(1, 1, 1'b1, 1'b0);
        pressKey(0, 1, 1'b1, 1'b0);
        pressKey(0, 1, 1'b1, 1'b0);
        checkOutput("load_1_00", 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(10'd0, 1'b0, 1'b1);
        checkOutput("before_first_tick", 1, 0, 0, 0, 0, 0);
        applyStimulus(10'd0, 1'b0, 1'b1);
        checkOutput("first_tick_0_59", 0, 5, 9, 0, 1, 0);
        runCount(236, ticks, dones);
        checkCount("minute_ticks", ticks, 59);
        checkCount("minute_dones", dones, 1);
        checkOutput("minute_end", 0, 0, 0, 1, 1, 1);
        runCount(20, ticks, dones);
        checkCount("no_tick_at_zero", ticks, 0);
        checkCount("no_done_at_zero", dones, 0);
        checkOutput("held_at_zero", 0, 0, 0, 1, 0, 0);

        // 0:75 counts 75 seconds
        applyStimulus(10'd0, 1'b1, 1'b0);
        pressKey(0, 1, 1'b1, 1'b0);
        pressKey(7, 1, 1'b1, 1'b0);
        pressKey(5, 1, 1'b1, 1'b0);
        checkOutput("load_0_75", 0, 7, 5, 0, 0, 0);
        for (int i = 0; i < 4; i++) applyStimulus(10'd0, 1'b0, 1'b1);
        checkOutput("tick_0_74", 0, 7, 4, 0, 1, 0);
        runCount(296, ticks, dones);
        checkCount("t75_ticks", ticks, 74);
        checkCount("t75_dones", dones, 1);
        checkOutput("t75_end", 0, 0, 0, 1, 1, 1);
        applyStimulus(10'd0, 1'b0, 1'b1);
        checkOutput("done_one_cycle", 0, 0, 0, 1, 0, 0);

        // Pause at prescaler=2 keeps the partial second
        doReset(10'd0, 1'b0);
        applyStimulus(10'd0, 1'b1, 1'b0);
        pressKey(3, 1, 1'b1, 1'b0);
        pressKey(0, 1, 1'b1, 1'b0);
        checkOutput("load_0_30", 0, 3, 0, 0, 0, 0);
        applyStimulus(10'd0, 1'b0, 1'b1);
        applyStimulus(10'd0, 1'b0, 1'b1);
        keypad   = 10'd0;
        load_en  = 1'b0;
        count_en = 1'b0;
        runCount(10, ticks, dones);
        checkCount("pause_ticks", ticks, 0);
        checkOutput("pause_digits", 0, 3, 0, 0, 0, 0);
        applyStimulus(10'd0, 1'b0, 1'b1);
        checkOutput("resume_plus1", 0, 3, 0, 0, 0, 0);
        applyStimulus(10'd0, 1'b0, 1'b1);
        checkOutput("resume_plus2", 0, 2, 9, 0, 1, 0);

        // Long hold, overflow of entry, press during counting
        doReset(10'd0, 1'b0);
        applyStimulus(10'd0, 1'b1, 1'b0);
        pressKey(3, 20, 1'b1, 1'b0);
        checkOutput("hold_single_shift", 0, 0, 3, 0, 0, 0);
        pressKey(1, 1, 1'b1, 1'b0);
        pressKey(2, 1, 1'b1, 1'b0);
        pressKey(3, 1, 1'b1, 1'b0);
        pressKey(4, 1, 1'b1, 1'b0);
        checkOutput("entry_2_34", 2, 3, 4, 0, 0, 0);
        applyStimulus(10'd0, 1'b1, 1'b0);
        pressKey(7, 1, 1'b1, 1'b1);
        checkOutput("press_while_counting", 2, 3, 4, 0, 0, 0);
        applyStimulus(10'd0, 1'b1, 1'b0);
        applyStimulus(10'd0, 1'b1, 1'b0);
        checkOutput("press_consumed", 2, 3, 4, 0, 0, 0);

        // Reset mid-count with a key held
        doReset(10'd0, 1'b0);
        applyStimulus(10'd0, 1'b1, 1'b0);
        pressKey(1, 1, 1'b1, 1'b0);
        pressKey(2, 1, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) applyStimulus(10'd0, 1'b0, 1'b1);
        checkOutput("midcount_0_11", 0, 1, 1, 0, 0, 0);
        applyStimulus(10'b0000100000, 1'b1, 1'b1);
        load_en = 1'b1;
        doReset(10'b0000100000, 1'b1);
        checkOutput("reset_midcount", 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 5; i++) applyStimulus(10'b0000100000, 1'b1, 1'b1);
        checkOutput("held_after_reset", 0, 0, 0, 1, 0, 0);
        applyStimulus(10'd0, 1'b1, 1'b0);
        applyStimulus(10'd0, 1'b1, 1'b0);
        pressKey(5, 1, 1'b1, 1'b0);
        checkOutput("repress_5", 0, 0, 5, 0, 0, 0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
Time-keeping stage between the keypad and the seven-segment decoders of the microwave.
- Captures one-hot keypad presses into a 3-digit BCD entry register (M:ST:SO).
- Counts that value down once per second while cooking is enabled.
- Drives the BCD digits the segment decoders consume, plus zero/done flags the cook controller uses to drop mag.

Parameters:
CLK_DIV, 50, clk cycles per second (50 Hz system clock); legal range 2..65535
KEY_W, 10, keypad width, one bit per digit 0..9

Ports:
clk  input  1  system clock, all state updates on rising edge
clearn  input  1  synchronous active-low reset
keypad  input  KEY_W  one-hot key lines, bit i = digit i; synchronous to clk
load_en  input  1  1 = entry mode; accepted presses shift into the digits
count_en  input  1  1 = cooking; countdown advances
sec_ones  output  4  BCD seconds-ones digit
sec_tens  output  4  BCD seconds-tens digit
mins  output  4  BCD minutes digit
zero  output  1  1 when all three digits are 0
tick  output  1  one-cycle pulse on each 1 s decrement
done  output  1  one-cycle pulse when a decrement reaches 0:00

Behaviour:
- Reset: clk and reset are fixed as above, one clock and a synchronous active-low reset named clearn. When clearn=0 at a rising edge:
  - digits clear to 0, prescaler clears to 0, key_q clears to 0.
  - tick and done drop to 0; zero=1.
  - Key FSM goes to HELD, so a key held through reset must be released before it is accepted.
  - Reset overrides every other input, including mid-count.
- Key path:
  - keypad is registered into key_q every cycle.
  - valid = key_q has exactly one bit set; digit = index of that bit.
- Key FSM, two states:
  - IDLE -> HELD when key_q != 0 (valid or not). On this transition, if valid, load_en=1 and count_en=0, shift the entry register: mins<=sec_tens, sec_tens<=sec_ones, sec_ones<=digit. The old mins value is discarded.
  - HELD -> IDLE when key_q == 0.
  - Result: one shift per press regardless of hold length. Multi-bit or invalid codes never shift and still require release.
  - Latency: a key applied before edge n is visible on the digits after edge n+1.
- Countdown:
  - Active when count_en=1 and zero=0.
  - Prescaler counts 0..CLK_DIV-1. On the cycle it equals CLK_DIV-1 it wraps to 0 and a decrement occurs at that edge; tick=1 during the cycle following the edge.
  - Decrement rules:
    - sec_ones!=0: sec_ones-1.
    - sec_ones==0, sec_tens!=0: sec_tens-1, sec_ones=9.
    - both 0: mins-1, sec_tens=5, sec_ones=9.
  - Entered tens digits >5 are legal and count naturally (0:75 lasts 75 s).
- Pause and stop:
  - count_en=0 holds the prescaler value (partial second preserved) and holds the digits.
  - When zero=1 the prescaler is forced to 0 and no decrement or tick occurs.
- Flags:
  - zero is combinational from the digit registers.
  - done=1 for exactly one cycle after the decrement that produces 0:00. Never asserted by reset or by loading zeros.
- Simultaneous events: count_en has priority over load_en. Presses during counting are consumed by the FSM (IDLE->HELD) but do not shift.
- Width rules: digits are always 0..9. Decrement never underflows because zero blocks it.

Decomposition:
- microwave_pkg holds:
  - bcd_t (4-bit digit type)
  - KEY_W
  - SEC_TENS_WRAP=5, SEC_ONES_WRAP=9
  - key FSM state enum {KEY_IDLE, KEY_HELD}
- Natural sub-module: keypad_encoder. It contains the key_q register, the one-hot check and the key FSM, and outputs press (one-cycle) and digit.
- countdown_timer instantiates keypad_encoder and owns the prescaler and digit registers.

Test Plan:
1. Reset, load_en=1; press 2, 5, 4 (each one cycle, released one cycle) -> mins=2, sec_tens=5, sec_ones=4, zero=0, no tick.
2. CLK_DIV=4; enter 1,0,0; load_en=0, count_en=1 -> tick every 4 cycles. After the first tick digits read 0:59; after 60 ticks 0:00 with done pulsed once and zero=1; no further ticks.
3. Enter 0,7,5; count -> after 1 tick 0:74; after 75 ticks 0:00 with done=1 for one cycle.
4. CLK_DIV=4; drop count_en when prescaler=2, hold 10 cycles, restore -> next decrement occurs 2 cycles after restore (1 more cycle with prescaler=3); digits unchanged during pause.
5. keypad=10'b0000000101 -> no shift. Digit 3 held 20 cycles -> single shift. Enter 1,2,3,4 -> 2:34 (1 discarded). Press 7 while count_en=1 and load_en=1 -> no shift.
6. Mid-count, clearn=0 for one cycle while key 5 held -> all digits 0, tick/done 0, no shift while 5 remains held. Release, press 5 again with load_en=1 -> sec_ones=5.
